// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator for a 2-wide front end: holds the fetch PC, handshakes
// with instruction memory, follows predictor hints and takes ROB redirects.
module if_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Imem_ready,
    input  logic             stall_in,
    input  logic             ROB_mispredict,
    input  logic [63:0]      ROB_redirect_addr,
    input  logic [1:0]       ptaken,
    input  logic [127:0]     paddress,
    output logic [127:0]     IF_PC,
    output logic [127:0]     IF_NPC,
    output logic [1:0]       IF_valid,
    output logic             if_req_valid,
    output logic [CNT_W-1:0] fetched_count
);

    typedef enum logic [1:0] {
        INIT   = 2'b00,
        RUN    = 2'b01,
        HOLD   = 2'b10,
        BUBBLE = 2'b11
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [63:0]      pc_r;
    logic [63:0]      next_pc_s;
    logic             req_r;
    logic             next_req_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic             fire_s;
    logic [63:0]      seq_pc_s;
    logic [63:0]      redirect_pc_s;
    logic             unused_s;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    assign IF_PC        = {pc_r + 64'd4, pc_r};
    assign IF_NPC       = {pc_r + 64'd8, pc_r + 64'd4};
    // Odd-word PC ends the 8-byte fetch block at slot0; a slot0 taken branch kills slot1.
    assign IF_valid     = req_r ? {~pc_r[2] & ~ptaken[0], 1'b1} : 2'b00;
    assign if_req_valid = req_r;
    assign fetched_count = cnt_r;

    assign fire_s        = req_r & Imem_ready & ~stall_in;
    assign seq_pc_s      = pc_r[2] ? (pc_r + 64'd4) : (pc_r + 64'd8);
    assign redirect_pc_s = {ROB_redirect_addr[63:2], 2'b00};
    assign unused_s      = ^{ROB_redirect_addr[1:0], paddress[65:64], paddress[1:0]};

    // Next-state, next-PC and counter update selection.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        next_req_s   = req_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            INIT: begin
                next_state_s = RUN;
                next_req_s   = 1'b1;
            end
            RUN, HOLD: begin
                if (ROB_mispredict) begin
                    next_state_s = BUBBLE;
                    next_pc_s    = redirect_pc_s;
                    next_req_s   = 1'b0;
                end else if (fire_s) begin
                    next_state_s = RUN;
                    next_req_s   = 1'b1;
                    next_cnt_s   = sat_add(cnt_r, popcount2(IF_valid));
                    if (ptaken[0]) begin
                        next_pc_s = {paddress[63:2], 2'b00};
                    end else if (!pc_r[2] && ptaken[1]) begin
                        next_pc_s = {paddress[127:66], 2'b00};
                    end else begin
                        next_pc_s = seq_pc_s;
                    end
                end else begin
                    next_state_s = HOLD;
                    next_req_s   = 1'b1;
                end
            end
            BUBBLE: begin
                if (ROB_mispredict) begin
                    next_state_s = BUBBLE;
                    next_pc_s    = redirect_pc_s;
                    next_req_s   = 1'b0;
                end else begin
                    next_state_s = RUN;
                    next_req_s   = 1'b1;
                end
            end
            default: begin
                next_state_s = INIT;
                next_pc_s    = RESET_PC;
                next_req_s   = 1'b0;
            end
        endcase
    end

    // FSM state, fetch PC, request flag and fetched-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= INIT;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            pc_r    <= next_pc_s;
            req_r   <= next_req_s;
            cnt_r   <= next_cnt_s;
        end
    end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
Fetch-stage PC generator for the 2-wide (`SCALAR=2) front end. Holds the fetch PC and drives the per-slot IF_PC/IF_NPC pair. IF_NPC feeds the branch_predictor lookup, and the block consumes its ptaken/paddress outputs combinationally in the same cycle to choose the next fetch PC. Handles fetch-request handshaking with instruction memory, downstream stalls, fetch-block alignment and ROB mispredict redirects.

Parameters:
RESET_PC, 64'h0, fetch address after reset; bits [2:0] must be 0.
CNT_W, 32, width of the saturating fetched-instruction counter.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
Imem_ready  in  1  instruction memory accepts a request this cycle.
stall_in  in  1  downstream fetch buffer cannot accept this cycle.
ROB_mispredict  in  1  retiring branch mispredicted; redirect fetch.
ROB_redirect_addr  in  64  correct target for the mispredicted branch.
ptaken  in  2  predictor taken flag per slot; bit0 = slot0.
paddress  in  128  predicted target per slot; slot0 = [63:0], slot1 = [127:64].
IF_PC  out  128  PC per slot; slot0 = pc, slot1 = pc+4.
IF_NPC  out  128  NPC per slot: PC+4 per slot. Drives predictor.
IF_valid  out  2  slot carries a real instruction this cycle.
if_req_valid  out  1  fetch request to instruction memory at IF_PC[63:0].
fetched_count  out  CNT_W  saturating count of valid slots accepted.

Behaviour:
- State register (FSM): INIT, RUN, HOLD, BUBBLE. Internal registers: pc[63:0], fetched_count.
- On reset low (async):
  - state = INIT, pc = RESET_PC, fetched_count = 0.
  - Outputs while in reset: IF_valid = 0, if_req_valid = 0.
- fire = if_req_valid & Imem_ready & ~stall_in.
- INIT:
  - if_req_valid = 0, IF_valid = 0.
  - Unconditionally goes to RUN on the next clk. This gives exactly one idle cycle after reset release.
- RUN / HOLD:
  - if_req_valid = 1.
  - IF_valid[0] = 1.
  - IF_valid[1] = ~pc[2] & ~ptaken[0]. An odd-word PC ends the 8-byte fetch block at slot0.
  - If fire:
    - next pc = paddress[63:0] if ptaken[0].
    - else, if pc[2]=0 and ptaken[1], next pc = paddress[127:64].
    - else next pc = pc+4 if pc[2]=1, otherwise pc+8.
    - State goes to RUN.
  - If not fire: pc holds, state goes to HOLD. Outputs are held stable while in HOLD.
- BUBBLE:
  - if_req_valid = 0, IF_valid = 0, pc holds.
  - Goes to RUN next cycle. This gives the predictor one cycle to absorb the ROB update.
- ROB_mispredict (highest priority, any state except INIT):
  - pc <= {ROB_redirect_addr[63:2], 2'b00}; state <= BUBBLE.
  - Overrides fire, stall_in and ptaken in the same cycle.
  - Slots presented during the mispredict cycle are not counted.
- ROB_mispredict in INIT is ignored.
- Arithmetic:
  - All PC adds are 64-bit, wrapping modulo 2^64. pc = 64'hFFFF_FFFF_FFFF_FFF8 with no taken branch goes to 0.
  - paddress is used as-is, except bits [1:0] are forced to 0.
- fetched_count:
  - On fire without mispredict, adds popcount(IF_valid), i.e. 1 or 2.
  - Saturates at 2^CNT_W-1.
- IF_PC/IF_NPC are combinational from pc. Slot1 values are driven even when IF_valid[1] = 0.
- Reset asserted mid-operation discards any pending redirect or hold. The first fetch after release is from RESET_PC.

Test Plan:
- Reset release, RESET_PC=0, Imem_ready=1, no branches:
  - cycle0: IF_valid = 00.
  - cycle1: IF_PC = {4,0}, IF_NPC = {8,4}, IF_valid = 11.
  - cycle2: pc = 8.
  - After 3 fetches, fetched_count = 6.
- pc=16 with ptaken=01, paddress[63:0]=100:
  - IF_valid = 01.
  - Next IF_PC slot0 = 100; slot1 = 104 invalid, since 100[2]=1.
  - Next pc after that = 104.
- pc=24 with ptaken=10, paddress[127:64]=200:
  - IF_valid = 11.
  - Next pc = 200.
  - Cycle after that: IF_PC[63:0] = 200.
- stall_in=1 for 3 cycles at pc=40:
  - IF_PC holds 40, if_req_valid = 1, fetched_count unchanged.
  - On release, pc becomes 48.
- ROB_mispredict=1 with ROB_redirect_addr=0x1003 while stall_in=1:
  - Next cycle: BUBBLE with IF_valid = 00.
  - Following cycle: IF_PC[63:0] = 0x1000, IF_valid = 11.
- Async reset low mid-HOLD at pc=300:
  - Outputs drop immediately: if_req_valid = 0, fetched_count = 0.
  - After release: INIT, then RUN at pc = RESET_PC.
